bcd_down_counter_2digits: RTL and testbench

- Loadable 2-decade BCD down-counter/timer, 99 to 00. Counterpart to the existing 0-99 up-counter.
- Used for countdown displays and timeouts. Drives the same 8-bit packed-BCD display path: tens in [7:4], ones in [3:0].
- Start/pause control, one-cycle done pulse at terminal count, optional prescaler.

---
 rtl/bcd_down_counter_2digits_pkg.sv | 20 ++
 rtl/bcd_down_counter_2digits_decade.sv | 28 ++
 rtl/bcd_down_counter_2digits.sv | 149 ++++++++++++++
 tb/tb_bcd_down_counter_2digits.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_down_counter_2digits_pkg.sv
// Shared definitions for the two-digit BCD down-counter:
// the controller state encoding, BCD constants and a digit clamp helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0] BCD_ZERO      = 8'h00;

    // Force a nibble into the legal BCD range; anything above 9 becomes 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] digit_in);
        return (digit_in > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : digit_in;
    endfunction

endpackage

// File: rtl/bcd_down_counter_2digits_decade.sv
// One BCD decade counting downward 9..0 with a borrow output.
// Chaining: the borrow of a lower decade enables the next higher decade.
module decade_down_counter
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       borrow
);

    // Digit register: reset, then load, then decrement with 0 wrapping to 9.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_digit;
        end else if (en) begin
            digit <= (digit == 4'd0) ? BCD_MAX_DIGIT : digit - 4'd1;
        end
    end

    assign borrow = en && (digit == 4'd0);

endmodule

// File: rtl/bcd_down_counter_2digits.sv
// Loadable two-decade BCD countdown timer (99 down to 00) with start/pause,
// a one-cycle done pulse at terminal count and a clock prescaler.
// Optional build macro AUTO_RELOAD_EN: on terminal count the counter reloads
// its last loaded value and keeps running instead of stopping at 00.
module bcd_down_counter_2digits
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] count,
    output logic       running,
    output logic       done
);

    localparam int             PW        = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    reload_reg;

    logic [7:0]    load_clamped;
    logic [7:0]    dec_value;
    logic          dec_load;
    logic          tick;
    logic          at_one;
    logic          reload_now;
    logic          ones_en;
    logic          ones_borrow;
    logic          tens_borrow;
    logic [3:0]    ones_digit;
    logic [3:0]    tens_digit;

    assign load_clamped = {clamp_digit(load_value[7:4]), clamp_digit(load_value[3:0])};

    // A tick only happens while genuinely running; load and pause both take
    // precedence over counting in the same cycle.
    assign tick   = (state == RUN) && !load && !pause && (presc == TICK_LAST);
    assign at_one = (count == 8'h01);

`ifdef AUTO_RELOAD_EN
    assign reload_now = tick && at_one && (reload_reg != BCD_ZERO);
`else
    assign reload_now = 1'b0;
`endif

    // The digits are loaded either from the user value or, on an automatic
    // wrap, from the reload register instead of decrementing to 00.
    assign dec_load  = load || reload_now;
    assign dec_value = load ? load_clamped : reload_reg;
    assign ones_en   = tick && !reload_now;

    decade_down_counter u_ones (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (ones_en),
        .load       (dec_load),
        .load_digit (dec_value[3:0]),
        .digit      (ones_digit),
        .borrow     (ones_borrow)
    );

    decade_down_counter u_tens (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (ones_borrow),
        .load       (dec_load),
        .load_digit (dec_value[7:4]),
        .digit      (tens_digit),
        .borrow     (tens_borrow)
    );

    assign count = {tens_digit, ones_digit};

    // Controller: state, prescaler, reload register and registered flags.
    // tens_borrow can only fire from 00, which RUN never holds; treating it as
    // terminal stops a corrupted count rather than letting it wrap forever.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc      <= '0;
            reload_reg <= BCD_ZERO;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                reload_reg <= load_clamped;
                state      <= IDLE;
                presc      <= '0;
                running    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            presc <= '0;
                            if (count != BCD_ZERO) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            presc <= '0;
                            if (reload_now) begin
                                done <= 1'b1;
                            end else if (at_one || tens_borrow) begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= DONE;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter_2digits.sv
// Directed bench for the two-digit BCD countdown timer. Two instances share
// the same stimulus: one with TICK_DIV=1, one with TICK_DIV=4.
module tb_bcd_down_counter_2digits;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;

    logic [7:0] count1;
    logic       running1;
    logic       done1;
    logic [7:0] count4;
    logic       running4;
    logic       done4;

    int total = 0;
    int bad   = 0;

    bcd_down_counter_2digits #(.TICK_DIV(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count1),
        .running    (running1),
        .done       (done1)
    );

    bcd_down_counter_2digits #(.TICK_DIV(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count4),
        .running    (running4),
        .done       (done4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the control inputs; called while the clock is low.
    task automatic applyStimulus(input logic rn, input logic ld, input logic [7:0] lv,
                                 input logic st, input logic pa);
        reset_n    = rn;
        load       = ld;
        load_value = lv;
        start      = st;
        pause      = pa;
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count one comparison and report any mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    initial begin
        logic [7:0] exp_val;

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        checkOutput("rst_count", count1, 8'h00);
        checkOutput("rst_running", {7'd0, running1}, 8'h00);
        checkOutput("rst_done", {7'd0, done1}, 8'h00);

        // Countdown 10 -> 00 at one decrement per clock.
        applyStimulus(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        cycle();
        checkOutput("load10", count1, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        checkOutput("start_running", {7'd0, running1}, 8'h01);
        checkOutput("start_count", count1, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 9; i >= 1; i--) begin
            cycle();
            exp_val = 8'(i);
            checkOutput($sformatf("down_%0d", i), count1, exp_val);
            checkOutput($sformatf("down_done_%0d", i), {7'd0, done1}, 8'h00);
            checkOutput($sformatf("down_run_%0d", i), {7'd0, running1}, 8'h01);
        end
        cycle();
        checkOutput("term_count", count1, 8'h00);
        checkOutput("term_done", {7'd0, done1}, 8'h01);
        checkOutput("term_running", {7'd0, running1}, 8'h00);
        cycle();
        checkOutput("done_drop", {7'd0, done1}, 8'h00);
        checkOutput("done_hold", count1, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        checkOutput("done_ignore_start", {7'd0, done1}, 8'h00);
        checkOutput("done_ignore_run", {7'd0, running1}, 8'h00);

        // Reset in the middle of a run, including a tens borrow 40 -> 39.
        applyStimulus(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        checkOutput("borrow_37", count1, 8'h37);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkOutput("midrst_count", count1, 8'h00);
        checkOutput("midrst_running", {7'd0, running1}, 8'h00);
        checkOutput("midrst_done", {7'd0, done1}, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkOutput("midrst_idle", {7'd0, running1}, 8'h00);

        // Pause/resume with TICK_DIV=4.
        applyStimulus(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        checkOutput("div4_before_tick", count4, 8'h05);
        cycle();
        checkOutput("div4_first_tick", count4, 8'h04);
        cycle();
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        checkOutput("pause_running", {7'd0, running4}, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        checkOutput("pause_hold", count4, 8'h04);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        checkOutput("resume_running", {7'd0, running4}, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkOutput("resume_wait", count4, 8'h04);
        cycle();
        checkOutput("resume_tick", count4, 8'h03);

        // Simultaneous controls: pause wins over start, load wins over start.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle();
        checkOutput("both_to_pause", {7'd0, running4}, 8'h00);
        cycle();
        checkOutput("both_stay_pause", {7'd0, running4}, 8'h00);
        checkOutput("both_count", count4, 8'h03);
        applyStimulus(1'b1, 1'b1, 8'h30, 1'b1, 1'b0);
        cycle();
        checkOutput("load_over_start", count4, 8'h30);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkOutput("load_to_idle", {7'd0, running4}, 8'h00);
        checkOutput("load_idle_count", count4, 8'h30);

        // Clamping and starting from zero.
        applyStimulus(1'b1, 1'b1, 8'hAF, 1'b0, 1'b0);
        cycle();
        checkOutput("clamp_AF", count1, 8'h99);
        applyStimulus(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
        cycle();
        checkOutput("clamp_5C", count1, 8'h59);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        checkOutput("zero_start_done", {7'd0, done1}, 8'h01);
        checkOutput("zero_start_run", {7'd0, running1}, 8'h00);
        cycle();
        checkOutput("zero_done_once", {7'd0, done1}, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        checkOutput("zero_restart_nodone", {7'd0, done1}, 8'h00);

        // Terminal count from 03, with or without automatic reload.
        applyStimulus(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkOutput("wrap_02", count1, 8'h02);
        cycle();
        checkOutput("wrap_01", count1, 8'h01);
        cycle();
        checkOutput("wrap_done", {7'd0, done1}, 8'h01);
`ifdef AUTO_RELOAD_EN
        checkOutput("wrap_count", count1, 8'h03);
        checkOutput("wrap_running", {7'd0, running1}, 8'h01);
        cycle();
        checkOutput("wrap_next", count1, 8'h02);
        checkOutput("wrap_done_drop", {7'd0, done1}, 8'h00);
`else
        checkOutput("wrap_count", count1, 8'h00);
        checkOutput("wrap_running", {7'd0, running1}, 8'h00);
        cycle();
        checkOutput("wrap_next", count1, 8'h00);
        checkOutput("wrap_done_drop", {7'd0, done1}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
